hex_display_pager: RTL and testbench

//  Parametrised seven-segment pager: captures a DATA_W-bit word and shows it
//  as pages of DIGITS hex nibbles on active-low displays. Page is picked by a

---
 rtl/hex_display_pager.sv | 125 ++++++++++++
 tb/tb_hex_display_pager.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_pager.sv
// Seven-segment pager: shows a captured word as pages of hex digits.
// Pages are chosen manually or rotated on a tick counter.
module hex_display_pager #(
    parameter int DATA_W     = 32,
    parameter int DIGITS     = 4,
    parameter int PAGE_TICKS = 24000000,
    localparam int PAGES     = DATA_W / (4 * DIGITS),
    localparam int PG_W      = (PAGES > 1) ? $clog2(PAGES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  data_valid,
    input  logic                  hold,
    input  logic                  auto_mode,
    input  logic [PG_W-1:0]       page_sel,
    input  logic                  blank_lz,
    output logic [7*DIGITS-1:0]   hex_n,
    output logic [PG_W-1:0]       page_idx,
    output logic                  page_wrap
);

    localparam int TICK_W = $clog2(PAGE_TICKS);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(PAGE_TICKS - 1);
    localparam logic [PG_W-1:0] PG_LAST = PG_W'(PAGES - 1);

    logic [DATA_W-1:0]   data_reg;
    logic [TICK_W-1:0]   tick_cnt;
    logic [7*DIGITS-1:0] hex_next;
    logic [PG_W-1:0]     sel_clamped;
    logic [DATA_W-1:0]   upper;
    logic [3:0]          nib;
    int                  idx;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Manual page request limited to the last existing page
    always_comb begin
        sel_clamped = page_sel;
        if (32'(page_sel) >= PAGES)
            sel_clamped = PG_LAST;
    end

    // Render the current page; a digit blanks when it and everything above is zero
    always_comb begin
        hex_next = '1;
        idx      = 0;
        upper    = '0;
        nib      = '0;
        for (int d = 0; d < DIGITS; d++) begin
            idx   = int'(page_idx) * DIGITS + d;
            upper = data_reg >> (4 * idx);
            nib   = upper[3:0];
            if (blank_lz && idx != 0 && upper == '0)
                hex_next[7*d +: 7] = 7'h7F;
            else
                hex_next[7*d +: 7] = seg7(nib);
        end
    end

    // Word capture, gated by hold
    always_ff @(posedge clk) begin
        if (!rst_n)
            data_reg <= '0;
        else if (data_valid && !hold)
            data_reg <= data_in;
    end

    // Registered segment outputs, blank while in reset
    always_ff @(posedge clk) begin
        if (!rst_n)
            hex_n <= '1;
        else
            hex_n <= hex_next;
    end

    // Page selection: follow switch in manual, rotate on tick period in auto
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            page_idx  <= '0;
            tick_cnt  <= '0;
            page_wrap <= 1'b0;
        end else if (auto_mode) begin
            page_wrap <= 1'b0;
            if (tick_cnt == TICK_LAST) begin
                tick_cnt <= '0;
                if (page_idx == PG_LAST) begin
                    page_idx  <= '0;
                    page_wrap <= 1'b1;
                end else begin
                    page_idx <= page_idx + 1'b1;
                end
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end else begin
            tick_cnt  <= '0;
            page_wrap <= 1'b0;
            page_idx  <= sel_clamped;
        end
    end

endmodule

// File: tb/tb_hex_display_pager.sv
// Bench for hex_display_pager: directed cases plus random stimulus
// against a word/page reference model, on two parameter sets.
module tb_hex_display_pager;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] data_in;
    logic        data_valid;
    logic        hold;
    logic        auto_mode;
    logic [1:0]  psel;
    logic        blank_lz;
    logic [27:0] hex0;
    logic        pg0;
    logic        wrap0;
    logic [13:0] hex1;
    logic [1:0]  pg1;
    logic        wrap1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hex_display_pager #(.DATA_W(32), .DIGITS(4), .PAGE_TICKS(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in),
        .data_valid(data_valid), .hold(hold), .auto_mode(auto_mode),
        .page_sel(psel[0]), .blank_lz(blank_lz),
        .hex_n(hex0), .page_idx(pg0), .page_wrap(wrap0)
    );

    hex_display_pager #(.DATA_W(24), .DIGITS(2), .PAGE_TICKS(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in[23:0]),
        .data_valid(data_valid), .hold(hold), .auto_mode(auto_mode),
        .page_sel(psel), .blank_lz(blank_lz),
        .hex_n(hex1), .page_idx(pg1), .page_wrap(wrap1)
    );

    // reference model: per-config word, page, tick count
    int          c_dig[2]   = '{4, 2};
    int          c_pages[2] = '{2, 3};
    int          c_ticks[2] = '{4, 3};
    logic [31:0] c_mask[2]  = '{32'hFFFF_FFFF, 32'h00FF_FFFF};
    logic [6:0]  seg[16]    = '{7'h40, 7'h79, 7'h24, 7'h30,
                                7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03,
                                7'h46, 7'h21, 7'h06, 7'h0E};
    logic [31:0] m_word[2];
    int          m_page[2];
    int          m_tick[2];
    logic [31:0] e_hex[2];
    logic        e_wrap[2];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] render(input logic [31:0] w,
                                           input int pg, input logic bl,
                                           input int dig);
        logic [31:0] r;
        logic [31:0] up;
        logic [6:0]  s;
        int          i;
        r = '0;
        for (int d = 0; d < dig; d++) begin
            i  = pg * dig + d;
            up = w >> (4 * i);
            s  = (bl && i != 0 && up == 0) ? 7'h7F : seg[up[3:0]];
            r  = r | (32'(s) << (7 * d));
        end
        return r;
    endfunction

    task automatic model_edge(input int k);
        int sel;
        if (!rst_n) begin
            m_word[k] = '0;
            m_page[k] = 0;
            m_tick[k] = 0;
            e_wrap[k] = 1'b0;
            e_hex[k]  = 32'((64'd1 << (7 * c_dig[k])) - 1);
        end else begin
            e_hex[k] = render(m_word[k], m_page[k], blank_lz, c_dig[k]);
            if (data_valid && !hold)
                m_word[k] = data_in & c_mask[k];
            e_wrap[k] = 1'b0;
            if (auto_mode) begin
                if (m_tick[k] == c_ticks[k] - 1) begin
                    m_tick[k] = 0;
                    m_page[k] = (m_page[k] + 1) % c_pages[k];
                    e_wrap[k] = (m_page[k] == 0);
                end else begin
                    m_tick[k]++;
                end
            end else begin
                m_tick[k] = 0;
                sel = (k == 0) ? int'(psel[0]) : int'(psel);
                m_page[k] = (sel >= c_pages[k]) ? c_pages[k] - 1 : sel;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check("hex0", 32'(hex0), e_hex[0]);
        check("page0", 32'(pg0), 32'(m_page[0]));
        check("wrap0", 32'(wrap0), 32'(e_wrap[0]));
        check("hex1", 32'(hex1), e_hex[1]);
        check("page1", 32'(pg1), 32'(m_page[1]));
        check("wrap1", 32'(wrap1), 32'(e_wrap[1]));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++)
            step();
    endtask

    initial begin
        rst_n      = 1'b0;
        data_in    = '0;
        data_valid = 1'b0;
        hold       = 1'b0;
        auto_mode  = 1'b0;
        psel       = '0;
        blank_lz   = 1'b0;

        steps(2);
        check("rst_blank", 32'(hex0), 32'h0FFF_FFFF);
        rst_n = 1'b1;
        step();
        check("post_rst", 32'(hex0), 32'({4{7'h40}}));

        data_in    = 32'h1234_ABCD;
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        step();
        check("pg0_abcd", 32'(hex0), 32'({7'h08, 7'h03, 7'h46, 7'h21}));
        psel = 2'd1;
        steps(2);
        check("pg1_1234", 32'(hex0), 32'({7'h79, 7'h24, 7'h30, 7'h19}));

        hold       = 1'b1;
        data_in    = 32'hFFFF_FFFF;
        data_valid = 1'b1;
        steps(2);
        check("hold", 32'(hex0), 32'({7'h79, 7'h24, 7'h30, 7'h19}));
        hold = 1'b0;
        step();
        data_valid = 1'b0;
        step();
        check("all_f", 32'(hex0), 32'({4{7'h0E}}));

        blank_lz   = 1'b1;
        data_in    = 32'h0000_00A5;
        data_valid = 1'b1;
        psel       = 2'd0;
        step();
        data_valid = 1'b0;
        step();
        check("lz_a5", 32'(hex0), 32'({7'h7F, 7'h7F, 7'h08, 7'h12}));
        psel = 2'd1;
        steps(2);
        check("lz_pg1", 32'(hex0), 32'h0FFF_FFFF);

        data_in    = 32'h0;
        data_valid = 1'b1;
        psel       = 2'd0;
        step();
        data_valid = 1'b0;
        step();
        check("lz_zero", 32'(hex0), 32'({7'h7F, 7'h7F, 7'h7F, 7'h40}));

        blank_lz  = 1'b0;
        auto_mode = 1'b1;
        steps(4);
        check("auto_p1", 32'(pg0), 32'd1);
        steps(4);
        check("auto_p0", 32'(pg0), 32'd0);
        check("auto_wrap", 32'(wrap0), 32'd1);
        step();
        check("wrap_pulse", 32'(wrap0), 32'd0);

        auto_mode = 1'b0;
        psel      = 2'd3;
        step();
        check("clamp1", 32'(pg1), 32'd2);
        check("sel0", 32'(pg0), 32'd1);

        auto_mode = 1'b1;
        steps(2);
        rst_n = 1'b0;
        step();
        check("rst_mid", 32'(pg0), 32'd0);
        rst_n = 1'b1;
        steps(3);
        check("tick_clr", 32'(pg0), 32'd0);
        step();
        check("tick_run", 32'(pg0), 32'd1);

        for (int n = 0; n < 600; n++) begin
            rst_n      = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 24) == 0)
                auto_mode = ~auto_mode;
            data_in    = $urandom;
            if ($urandom_range(0, 1) == 0)
                data_in = data_in >> (4 * $urandom_range(0, 7));
            data_valid = ($urandom_range(0, 2) == 0);
            hold       = ($urandom_range(0, 3) == 0);
            psel       = 2'($urandom_range(0, 3));
            blank_lz   = 1'($urandom_range(0, 1));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
